// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcode constants, the fetch-sequencer state type
// and the instruction size.
package riscv_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_NOP    = 7'b0000000;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam int unsigned INST_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } fetch_state_t;

    // A fetch address is legal only when it sits on an instruction boundary.
    function automatic logic word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating event counter with synchronous clear; clear has priority over the
// enable.
module fetch_perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Count enabled cycles and stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter controller. The optional performance counters (cycle_cnt,
// retire_cnt) are included when FETCH_SEQ_PERF_EN is defined.
module fetch_sequencer
    import riscv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_INST = 19,
    parameter int RESET_PC = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             restart,
    input  logic             stall,
    input  logic [6:0]       opcode,
    input  logic             branch,
    input  logic             jump,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             flush,
    output logic             halted,
    output logic             err_misalign
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [WIDTH-1:0] cycle_cnt,
    output logic [WIDTH-1:0] retire_cnt
`endif
);

    localparam logic [WIDTH-1:0] RESET_ADDR = WIDTH'(RESET_PC);
    localparam logic [WIDTH-1:0] END_ADDR   = WIDTH'(NUM_INST * INST_BYTES);
    localparam logic [WIDTH-1:0] STEP       = WIDTH'(INST_BYTES);

    fetch_state_t     state_r;
    fetch_state_t     next_state_s;
    logic [WIDTH-1:0] next_pc_s;
    logic [WIDTH-1:0] pc_plus4_s;
    logic             next_err_s;
    logic             redirect_s;
    logic             next_pc_valid_s;
    logic             next_flush_s;
    logic             next_halted_s;

    // Wraps modulo 2^WIDTH; the end-of-ROM compare below is unsigned.
    assign pc_plus4_s = pc + STEP;
    assign redirect_s = jump | (branch & branch_taken);

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            pc           <= RESET_ADDR;
            err_misalign <= 1'b0;
            pc_valid     <= 1'b0;
            flush        <= 1'b0;
            halted       <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            pc           <= next_pc_s;
            err_misalign <= next_err_s;
            pc_valid     <= next_pc_valid_s;
            flush        <= next_flush_s;
            halted       <= next_halted_s;
        end
    end

    // Next-state, next-PC and sticky-error decision.
    always_comb begin
        next_state_s = state_r;
        next_pc_s    = pc;
        next_err_s   = err_misalign;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = FETCH;
                    next_pc_s    = RESET_ADDR;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FETCH: begin
                if (stall) begin
                    next_state_s = FETCH;
                end else if (redirect_s) begin
                    if (!word_aligned(target[1:0])) begin
                        next_err_s   = 1'b1;
                        next_state_s = HALT;
                    end else begin
                        next_pc_s    = target;
                        next_state_s = REDIRECT;
                    end
                end else if (opcode == OP_NOP) begin
                    next_state_s = HALT;
                end else if (pc_plus4_s >= END_ADDR) begin
                    next_state_s = HALT;
                end else begin
                    next_pc_s    = pc_plus4_s;
                    next_state_s = FETCH;
                end
            end
            REDIRECT: begin
                next_state_s = FETCH;
            end
            HALT: begin
                if (restart) begin
                    next_state_s = FETCH;
                    next_pc_s    = RESET_ADDR;
                    next_err_s   = 1'b0;
                end else begin
                    next_state_s = HALT;
                end
            end
            default: begin
                next_state_s = IDLE;
                next_pc_s    = RESET_ADDR;
                next_err_s   = 1'b0;
            end
        endcase
    end

    // Status outputs follow the state being entered so they line up with pc.
    always_comb begin
        next_pc_valid_s = 1'b0;
        next_flush_s    = 1'b0;
        next_halted_s   = 1'b0;
        case (next_state_s)
            FETCH:    next_pc_valid_s = 1'b1;
            REDIRECT: next_flush_s    = 1'b1;
            HALT:     next_halted_s   = 1'b1;
            default: begin
                next_pc_valid_s = 1'b0;
                next_flush_s    = 1'b0;
                next_halted_s   = 1'b0;
            end
        endcase
    end

`ifdef FETCH_SEQ_PERF_EN
    logic cnt_clear_s;
    logic cycle_en_s;
    logic retire_en_s;

    assign cnt_clear_s = (state_r == HALT) & restart;
    assign cycle_en_s  = (state_r != IDLE);
    assign retire_en_s = (state_r == FETCH) & ~stall & (next_state_s != HALT);

    fetch_perf_counter #(.WIDTH(WIDTH)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear_s),
        .en    (cycle_en_s),
        .count (cycle_cnt)
    );

    fetch_perf_counter #(.WIDTH(WIDTH)) u_retire_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear_s),
        .en    (retire_en_s),
        .count (retire_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

    localparam int          NUM_INST = 19;
    localparam logic [31:0] END_ADDR = 32'(NUM_INST * 4);
    localparam logic [6:0]  ADDI     = 7'b0010011;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_BUBBLE = 2;
    localparam int M_STOP   = 3;

    logic        clk = 1'b0;
    logic        rst, start, restart, stall, branch, jump, branch_taken;
    logic [6:0]  opcode;
    logic [31:0] target;
    logic [31:0] pc;
    logic        pc_valid, flush, halted, err_misalign;
`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] cycle_cnt, retire_cnt;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;

    int          m_mode = M_IDLE;
    logic [31:0] m_pc   = 32'd0;
    logic        m_err  = 1'b0;
    logic [31:0] m_cyc  = 32'd0;
    logic [31:0] m_ret  = 32'd0;

    fetch_sequencer #(.WIDTH(32), .NUM_INST(NUM_INST), .RESET_PC(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .restart      (restart),
        .stall        (stall),
        .opcode       (opcode),
        .branch       (branch),
        .jump         (jump),
        .branch_taken (branch_taken),
        .target       (target),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .flush        (flush),
        .halted       (halted),
        .err_misalign (err_misalign)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .retire_cnt   (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the reference by one clock using the inputs held across the edge.
    task automatic model_step();
        int          nm   = m_mode;
        logic [31:0] npc  = m_pc;
        logic        nerr = m_err;
        logic [31:0] seq  = m_pc + 32'd4;
        if (rst) begin
            nm = M_IDLE; npc = 32'd0; nerr = 1'b0; m_cyc = 32'd0; m_ret = 32'd0;
        end else begin
            case (m_mode)
                M_IDLE:   if (start) begin nm = M_RUN; npc = 32'd0; end
                M_RUN: if (!stall) begin
                    if (jump || (branch && branch_taken)) begin
                        if ((target % 4) != 0) begin nerr = 1'b1; nm = M_STOP; end
                        else begin npc = target; nm = M_BUBBLE; end
                    end else if (opcode == 7'd0) nm = M_STOP;
                    else if (seq >= END_ADDR) nm = M_STOP;
                    else npc = seq;
                end
                M_BUBBLE: nm = M_RUN;
                default:  if (restart) begin nm = M_RUN; npc = 32'd0; nerr = 1'b0; end
            endcase
            if (m_mode == M_STOP && restart) begin
                m_cyc = 32'd0; m_ret = 32'd0;
            end else begin
                if (m_mode != M_IDLE && m_cyc != 32'hFFFF_FFFF) m_cyc++;
                if (m_mode == M_RUN && !stall && nm != M_STOP && m_ret != 32'hFFFF_FFFF) m_ret++;
            end
        end
        m_mode = nm; m_pc = npc; m_err = nerr;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("pc", pc, m_pc);
        check("pc_valid", 32'(pc_valid), 32'(m_mode == M_RUN));
        check("flush", 32'(flush), 32'(m_mode == M_BUBBLE));
        check("halted", 32'(halted), 32'(m_mode == M_STOP));
        check("err_misalign", 32'(err_misalign), 32'(m_err));
`ifdef FETCH_SEQ_PERF_EN
        check("cycle_cnt", cycle_cnt, m_cyc);
        check("retire_cnt", retire_cnt, m_ret);
`endif
    endtask

    initial begin
        int guard;
        rst = 1'b1; start = 1'b0; restart = 1'b0; stall = 1'b0;
        branch = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        opcode = ADDI; target = 32'd0;

        step(); step();
        check("reset_pc", pc, 32'd0);
        check("reset_valid", 32'(pc_valid), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        rst = 1'b0;
        step();
        check("idle_valid", 32'(pc_valid), 32'd0);
        start = 1'b1; step(); start = 1'b0;
        check("first_valid", 32'(pc_valid), 32'd1);
        check("first_pc", pc, 32'd0);
        step(); check("seq_pc4", pc, 32'd4);
        step(); check("seq_pc8", pc, 32'd8);
        step(); check("seq_pc12", pc, 32'd12);

        branch = 1'b1; branch_taken = 1'b1; target = 32'h18; step();
        check("br_pc", pc, 32'h18);
        check("br_flush", 32'(flush), 32'd1);
        check("br_bubble_valid", 32'(pc_valid), 32'd0);
        branch = 1'b0; branch_taken = 1'b0; step();
        check("br_resume_valid", 32'(pc_valid), 32'd1);
        check("br_resume_pc", pc, 32'h18);
        branch = 1'b1; step(); branch = 1'b0;
        check("br_not_taken_pc", pc, 32'h1C);
        check("br_not_taken_flush", 32'(flush), 32'd0);

        rst = 1'b1; step(); rst = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        stall = 1'b1; jump = 1'b1; target = 32'h20;
        step(); step(); step();
        check("stall_pc_hold", pc, 32'd8);
        check("stall_valid", 32'(pc_valid), 32'd1);
        stall = 1'b0; step(); jump = 1'b0;
        check("jump_pc", pc, 32'h20);
        check("jump_flush", 32'(flush), 32'd1);
        step();

        guard = 0;
        while (pc !== 32'd72 && guard < 40) begin step(); guard++; end
        check("reach_pc72", pc, 32'd72);
        step();
        check("eor_halted", 32'(halted), 32'd1);
        check("eor_pc", pc, 32'd72);
        step();
        check("eor_pc_frozen", pc, 32'd72);
        restart = 1'b1; step(); restart = 1'b0;
        check("restart_pc", pc, 32'd0);
        check("restart_valid", 32'(pc_valid), 32'd1);
        repeat (5) step();
        check("reach_pc20", pc, 32'd20);
        opcode = 7'd0; step(); opcode = ADDI;
        check("nop_halted", 32'(halted), 32'd1);
        check("nop_pc", pc, 32'd20);

        restart = 1'b1; step(); restart = 1'b0;
        jump = 1'b1; target = 32'h22; step(); jump = 1'b0;
        check("mis_err", 32'(err_misalign), 32'd1);
        check("mis_halted", 32'(halted), 32'd1);
        restart = 1'b1; step(); restart = 1'b0;
        check("mis_cleared", 32'(err_misalign), 32'd0);
        branch = 1'b1; branch_taken = 1'b1; target = 32'h40; step();
        branch = 1'b0; branch_taken = 1'b0;
        check("redir_flush", 32'(flush), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        check("rst_mid_pc", pc, 32'd0);
        check("rst_mid_flush", 32'(flush), 32'd0);
        check("rst_mid_valid", 32'(pc_valid), 32'd0);

`ifdef FETCH_SEQ_PERF_EN
        start = 1'b1; step(); start = 1'b0;
        repeat (5) step();
        jump = 1'b1; target = 32'd0; step(); jump = 1'b0;
        step();
        check("perf_retire", retire_cnt, 32'd6);
        check("perf_cycle", cycle_cnt, 32'd7);
`endif

        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 199) == 0);
            start        = ($urandom_range(0, 7) == 0);
            restart      = ($urandom_range(0, 5) == 0);
            stall        = ($urandom_range(0, 4) == 0);
            opcode       = ($urandom_range(0, 11) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            branch       = ($urandom_range(0, 5) == 0);
            branch_taken = $urandom_range(0, 1) == 1;
            jump         = ($urandom_range(0, 9) == 0);
            target       = 32'($urandom_range(0, 90)) * 32'd4;
            if ($urandom_range(0, 9) == 0) target = target + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 49) == 0) target = 32'hFFFF_FFFC;
            step();
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
